// File: rtl/pipelined_write_decoder_pkg.sv
// Shared sizing helpers and types for the registered write-port decoder.
package decoder_pkg;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int DEF_ADDR_W       = 5;
  localparam int DEF_ZERO_REG_IDX = 31;

  typedef logic [depth_of(DEF_ADDR_W)-1:0] onehot_t;

endpackage

// File: rtl/pipelined_write_decoder_if.sv
// Writeback-to-register-file bus: decode requests in, registered enables out.
interface decoder_if
  import decoder_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_PORTS = 2,
  parameter int CNT_W     = 8
);
  localparam int DEPTH = depth_of(ADDR_W);

  logic                        enable;
  logic                        flush;
  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS*ADDR_W-1:0] in_addr;
  logic [NUM_PORTS*DEPTH-1:0]  out_onehot;
  logic [DEPTH-1:0]            out_any;
  logic                        out_valid;
  logic                        conflict;
  logic [CNT_W-1:0]            conflict_count;

  modport master (
    output enable, flush, in_valid, in_addr,
    input  out_onehot, out_any, out_valid, conflict, conflict_count
  );

  modport slave (
    input  enable, flush, in_valid, in_addr,
    output out_onehot, out_any, out_valid, conflict, conflict_count
  );
endinterface

// File: rtl/pipelined_write_decoder_n_to_onehot.sv
// Combinational single-port N-to-2**N one-hot decoder with enable.
module n_to_onehot_decoder #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]      in,
  input  logic                   enable,
  output logic [(1<<ADDR_W)-1:0] out
);
  always_comb begin
    out = '0;
    if (enable) out[in] = 1'b1;
  end
endmodule

// File: rtl/pipelined_write_decoder.sv
// Multi-port registered write-enable decoder: zero-register masking,
// lowest-port-wins arbitration on collisions, saturating conflict counter.
module pipelined_write_decoder
  import decoder_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int NUM_PORTS    = 2,
  parameter int ZERO_REG_EN  = 1,
  parameter int ZERO_REG_IDX = DEF_ZERO_REG_IDX,
  parameter int CNT_W        = 8
) (
  input  logic      clk,
  input  logic      reset_n,
  decoder_if.slave  bus
);
  localparam int                DEPTH   = depth_of(ADDR_W);
  localparam bit                ZEN     = (ZERO_REG_EN != 0);
  localparam logic [ADDR_W-1:0] ZIDX    = ADDR_W'(ZERO_REG_IDX);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [NUM_PORTS-1:0][DEPTH-1:0] raw;
  logic [NUM_PORTS-1:0][DEPTH-1:0] onehot_d, onehot_q;
  logic [DEPTH-1:0]                any_d, any_q, claimed;
  logic                            conf_d, conf_q, valid_q;
  logic [CNT_W-1:0]                cnt_d, cnt_q;

  // Zero-register hits are masked at the decoder enable so they can never collide.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic              en;
    assign addr = bus.in_addr[p*ADDR_W +: ADDR_W];
    assign en   = bus.enable & bus.in_valid[p] & ~(ZEN & (addr == ZIDX));
    n_to_onehot_decoder #(.ADDR_W(ADDR_W)) u_dec (
      .in     (addr),
      .enable (en),
      .out    (raw[p])
    );
  end

  // Walk ports low to high; a port whose line is already claimed loses entirely.
  always_comb begin
    claimed  = '0;
    conf_d   = 1'b0;
    onehot_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (|(raw[p] & claimed)) conf_d = 1'b1;
      else                     onehot_d[p] = raw[p];
      claimed = claimed | raw[p];
    end
    any_d = claimed;
    cnt_d = cnt_q;
    if (!bus.flush && conf_d && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      onehot_q <= '0;
      any_q    <= '0;
      valid_q  <= 1'b0;
      conf_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (bus.flush) begin
      onehot_q <= '0;
      any_q    <= '0;
      valid_q  <= 1'b0;
      conf_q   <= 1'b0;
    end else begin
      onehot_q <= onehot_d;
      any_q    <= any_d;
      valid_q  <= |any_d;
      conf_q   <= conf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.out_onehot     = onehot_q;
  assign bus.out_any        = any_q;
  assign bus.out_valid      = valid_q;
  assign bus.conflict       = conf_q;
  assign bus.conflict_count = cnt_q;

endmodule

// File: tb/tb_pipelined_write_decoder.sv
// Randomized scoreboard bench for pipelined_write_decoder (2 ports, 5-bit addresses).
module tb_pipelined_write_decoder;
  localparam int AW = 5;
  localparam int NP = 2;
  localparam int D  = 32;
  localparam int CW = 8;

  typedef struct {
    logic [NP*D-1:0] oh;
    logic [D-1:0]    any;
    logic            valid;
    logic            conf;
    logic [CW-1:0]   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   mcnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  decoder_if #(.ADDR_W(AW), .NUM_PORTS(NP), .CNT_W(CW)) bus ();

  pipelined_write_decoder #(
    .ADDR_W(AW), .NUM_PORTS(NP), .ZERO_REG_EN(1), .ZERO_REG_IDX(31), .CNT_W(CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ports claim addresses in ascending order; an already-claimed
  // address means the request is lost and the cycle is a conflict cycle.
  task automatic drive(input logic en, input logic fl, input logic [NP-1:0] v,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    exp_t e;
    bit   used[D];
    int   addr[NP];
    @(negedge clk);
    bus.enable = en; bus.flush = fl; bus.in_valid = v; bus.in_addr = {a1, a0};
    addr[0] = int'(a0); addr[1] = int'(a1);
    e.oh = '0; e.any = '0; e.conf = 1'b0;
    foreach (used[i]) used[i] = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (!fl && en && v[p] && addr[p] != 31) begin
        if (used[addr[p]]) e.conf = 1'b1;
        else begin
          used[addr[p]] = 1'b1;
          e.oh[p*D + addr[p]] = 1'b1;
        end
      end
    end
    for (int i = 0; i < D; i++) e.any[i] = used[i];
    e.valid = (e.any != 0);
    if (e.conf && mcnt < 255) mcnt++;
    e.cnt = CW'(mcnt);
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string name);
    cmp({name, "_onehot"}, 64'(bus.out_onehot), 64'h0);
    cmp({name, "_any"},    64'(bus.out_any), 64'h0);
    cmp({name, "_valid"},  64'(bus.out_valid), 64'h0);
    cmp({name, "_conf"},   64'(bus.conflict), 64'h0);
    cmp({name, "_cnt"},    64'(bus.conflict_count), 64'h0);
  endtask

  // Monitor: every scheduled decode is compared just after the edge that registers it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("sb_onehot", 64'(bus.out_onehot), 64'(e.oh));
      cmp("sb_any",    64'(bus.out_any), 64'(e.any));
      cmp("sb_valid",  64'(bus.out_valid), 64'(e.valid));
      cmp("sb_conf",   64'(bus.conflict), 64'(e.conf));
      cmp("sb_cnt",    64'(bus.conflict_count), 64'(e.cnt));
    end
  end

  initial begin
    bus.enable = 1'b1; bus.flush = 1'b0; bus.in_valid = 2'b11; bus.in_addr = {5'd9, 5'd5};
    repeat (3) @(posedge clk);
    #2 check_all_zero("reset_hold");
    @(negedge clk);
    bus.in_valid = 2'b00;
    reset_n = 1'b1;

    // Basic decode
    drive(1'b1, 1'b0, 2'b11, 5'd5, 5'd9);
    @(posedge clk); #2;
    cmp("basic_any",   64'(bus.out_any), 64'h0000_0220);
    cmp("basic_p0",    64'(bus.out_onehot[D-1:0]), 64'h20);
    cmp("basic_p1",    64'(bus.out_onehot[2*D-1:D]), 64'h200);
    cmp("basic_valid", 64'(bus.out_valid), 64'h1);

    // Conflict, then saturation
    drive(1'b1, 1'b0, 2'b11, 5'd12, 5'd12);
    @(posedge clk); #2;
    cmp("conf_p0",  64'(bus.out_onehot[D-1:0]), 64'h1000);
    cmp("conf_p1",  64'(bus.out_onehot[2*D-1:D]), 64'h0);
    cmp("conf_bit", 64'(bus.conflict), 64'h1);
    cmp("conf_cnt", 64'(bus.conflict_count), 64'h1);
    drive(1'b1, 1'b0, 2'b11, 5'd3, 5'd4);
    @(posedge clk); #2;
    cmp("conf_pulse_end", 64'(bus.conflict), 64'h0);
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b0, 2'b11, 5'd12, 5'd12);
    @(posedge clk); #2;
    cmp("cnt_saturated", 64'(bus.conflict_count), 64'd255);

    // Zero register, enable/valid gating, flush
    drive(1'b1, 1'b0, 2'b11, 5'd31, 5'd31);
    @(posedge clk); #2;
    cmp("zero_valid", 64'(bus.out_valid), 64'h0);
    cmp("zero_conf",  64'(bus.conflict), 64'h0);
    drive(1'b0, 1'b0, 2'b11, 5'd1, 5'd1);
    drive(1'b1, 1'b0, 2'b10, 5'd7, 5'd0);
    @(posedge clk); #2;
    cmp("valid_gate_any", 64'(bus.out_any), 64'h1);
    cmp("valid_gate_p0",  64'(bus.out_onehot[D-1:0]), 64'h0);
    drive(1'b1, 1'b1, 2'b11, 5'd12, 5'd12);
    drive(1'b1, 1'b0, 2'b11, 5'd2, 5'd30);

    // Asynchronous reset while out_valid is high
    drive(1'b1, 1'b0, 2'b01, 5'd6, 5'd0);
    @(posedge clk); #3;
    cmp("pre_reset_valid", 64'(bus.out_valid), 64'h1);
    reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    mcnt = 0;
    @(negedge clk);
    bus.in_valid = 2'b00; bus.flush = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic; narrow address range forces collisions and zero-register hits
    for (int i = 0; i < 500; i++) begin
      logic           en, fl;
      logic [NP-1:0]  v;
      logic [AW-1:0]  a0, a1;
      en = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 9) == 0);
      v  = NP'($urandom);
      a0 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(28, 31)) : AW'($urandom);
      a1 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(28, 31)) : AW'($urandom);
      drive(en, fl, v, a0, a1);
    end

    @(posedge clk); #3;
    cmp("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_write_decoder.md
Name: pipelined_write_decoder

Overview:
- Parametrised, registered successor to the 2-to-4 gate-level decoder.
- Decodes NUM_PORTS independent ADDR_W-bit write addresses into one-hot register-file write enables, 2**ADDR_W lines per port.
- Adds a one-cycle output register, zero-register write suppression, same-cycle write-conflict arbitration and a saturating conflict counter.
- Sits between the ALU writeback stage and the 32x64 register file.

Parameters:
- ADDR_W, 5: address width per port; output width per port is DEPTH = 2**ADDR_W.
- NUM_PORTS, 2: number of independent write ports; legal range 1..4.
- ZERO_REG_EN, 1: 1 = writes to ZERO_REG_IDX are suppressed (ARM XZR).
- ZERO_REG_IDX, 31: index of the hard-wired zero register; must be < DEPTH.
- CNT_W, 8: width of the conflict counter.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  global decode enable; 0 forces all decoded lines to 0
- flush  input  1  synchronous clear of output registers; wins over all inputs
- in_valid  input  NUM_PORTS  per-port write request
- in_addr  input  NUM_PORTS*ADDR_W  packed addresses; port p at [p*ADDR_W +: ADDR_W]
- out_onehot  output  NUM_PORTS*DEPTH  registered per-port one-hot; port p at [p*DEPTH +: DEPTH]
- out_any  output  DEPTH  registered bitwise OR of all ports' one-hot vectors
- out_valid  output  1  registered; 1 when any bit of out_any is 1
- conflict  output  1  registered one-cycle pulse; a same-address collision was arbitrated
- conflict_count  output  CNT_W  saturating count of conflict cycles

Behaviour:
- Reset (reset_n low, asynchronous): out_onehot, out_any, out_valid, conflict and conflict_count all go to 0 immediately.
- Release of reset takes effect at the first clk edge after reset_n rises.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- No backpressure. Every cycle is a new independent decode.
- Per-port decode (combinational, before the register):
  - line[p][i] = enable & in_valid[p] & (in_addr[p] == i).
  - Zero-register rule: when ZERO_REG_EN = 1 and in_addr[p] == ZERO_REG_IDX, line[p] is all-0. The request is dropped silently and counts toward nothing.
- Arbitration:
  - Applies when two or more ports have nonzero decoded lines at the same index.
  - The lowest-numbered port keeps its line. Every higher-numbered colliding port's vector is cleared to all-0.
  - The conflict register is set to 1 for that cycle.
  - Only one conflict pulse per cycle, however many ports collide.
  - Ports addressing the zero register never collide.
  - enable = 0 suppresses all lines, so it also suppresses conflicts.
- out_any = OR over ports of the post-arbitration vectors. Each bit of out_any therefore has at most one contributing port.
- out_valid = |out_any, registered in the same cycle as out_any.
- conflict_count:
  - Increments by 1 on every edge where the conflict register is loaded with 1.
  - Holds at 2**CNT_W - 1; no wrap.
  - Cleared only by reset. flush does not clear it.
- flush = 1 at an edge:
  - out_onehot, out_any, out_valid and conflict load 0.
  - Inputs in that cycle are discarded and not counted.
- No output depends combinationally on any input.
- Every output bit is a flop output, which gives a glitch-free drive to the register-file write enables.

Decomposition:
- Package decoder_pkg holds:
  - localparam function depth_of(addr_w) = 2**addr_w;
  - the default ZERO_REG_IDX constant (31);
  - typedef onehot_t as a logic vector of DEPTH for the 5-bit default.
- Sub-module n_to_onehot_decoder (params ADDR_W; ports in, enable, out):
  - purely combinational;
  - the generalised single-port decoder, instantiated NUM_PORTS times via generate;
  - zero-register masking and arbitration stay in the top level.

Test Plan:
- Reset: hold reset_n = 0 with enable = 1, in_valid = 2'b11 -> every output 0. Drive reset_n low mid-operation with out_valid = 1 -> outputs go to 0 before the next clk edge.
- Basic decode: enable = 1, port0 addr 5, port1 addr 9, both valid -> next cycle out_onehot port0 = 1<<5, port1 = 1<<9, out_any = 32'h0000_0220, out_valid = 1, conflict = 0.
- Conflict: both ports addr 12, valid -> port0 = 1<<12, port1 = 0, out_any = 1<<12, conflict = 1 for one cycle, conflict_count = 1. Repeat 300 consecutive cycles -> conflict_count saturates at 255.
- Zero register: port0 addr 31, port1 addr 31, both valid -> all outputs 0, conflict = 0, conflict_count unchanged.
- Enable/valid gating: enable = 0 with valid addresses -> outputs 0. enable = 1, in_valid = 2'b10, port1 addr 0 -> out_any = 32'h1, port0 vector = 0.
- Flush: flush = 1 together with a colliding request -> outputs 0, conflict = 0, conflict_count unchanged. The next cycle with flush = 0 decodes normally.
